// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester.
package apb_pkg;

  // Transfer phases of the requester state machine.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

endpackage

// File: rtl/apb_master.sv
// APB requester: takes one command at a time, runs SETUP/ACCESS on the bus,
// and holds the result on the rsp_* port until it is consumed.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  // A zero timeout still needs a one-bit counter so the logic stays legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  apb_mst_state_e        state_reg, state_next;
  logic                  psel_reg, psel_next;
  logic                  penable_reg, penable_next;
  logic                  pwrite_reg, pwrite_next;
  logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
  logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic                  rsp_timeout_reg, rsp_timeout_next;
  logic [CNT_W-1:0]      wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]      wait_cnt_inc;

  // Saturating increment: the wait counter must never wrap back to zero.
  assign wait_cnt_inc = (wait_cnt_reg == CNT_MAX) ? wait_cnt_reg : wait_cnt_reg + CNT_W'(1);

  // State and all bus/response outputs are registered; reset abandons any transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg       <= IDLE;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      wait_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      pwrite_reg      <= pwrite_next;
      paddr_reg       <= paddr_next;
      pwdata_reg      <= pwdata_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
      wait_cnt_reg    <= wait_cnt_next;
    end
  end

  // Next-state and next-output logic; everything holds unless a phase changes it.
  always_comb begin
    state_next       = state_reg;
    psel_next        = psel_reg;
    penable_next     = penable_reg;
    pwrite_next      = pwrite_reg;
    paddr_next       = paddr_reg;
    pwdata_next      = pwdata_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_err_next     = rsp_err_reg;
    rsp_timeout_next = rsp_timeout_reg;
    wait_cnt_next    = wait_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          state_next    = SETUP;
          psel_next     = 1'b1;
          penable_next  = 1'b0;
          pwrite_next   = cmd_write;
          paddr_next    = cmd_addr;
          pwdata_next   = cmd_wdata;
          wait_cnt_next = '0;
        end
      end
      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_next       = RESP;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_err_next     = PSLVERR;
          rsp_timeout_next = 1'b0;
          // Only a clean read returns bus data; anything else is forced to zero.
          rsp_rdata_next   = (!pwrite_reg && !PSLVERR) ? PRDATA : '0;
        end else begin
          wait_cnt_next = wait_cnt_inc;
          if ((TIMEOUT_CYCLES != 0) && (wait_cnt_inc == CNT_LIMIT)) begin
            state_next       = RESP;
            psel_next        = 1'b0;
            penable_next     = 1'b0;
            rsp_valid_next   = 1'b1;
            rsp_err_next     = 1'b1;
            rsp_timeout_next = 1'b1;
            rsp_rdata_next   = '0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next       = IDLE;
          rsp_valid_next   = 1'b0;
          rsp_err_next     = 1'b0;
          rsp_timeout_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cmd_ready   = (state_reg == IDLE);
  assign PSEL        = psel_reg;
  assign PENABLE     = penable_reg;
  assign PWRITE      = pwrite_reg;
  assign PADDR       = paddr_reg;
  assign PWDATA      = pwdata_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, PADDR and cmd_addr width.
REQ-002 Parameter DATA_WIDTH, default 32, PWDATA, PRDATA, cmd_wdata and rsp_rdata width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum wait-state cycles in ACCESS; 0 disables the timeout.
REQ-004 PCLK  input  1  single clock; all logic on its rising edge.
REQ-005 PRESETn  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  master can accept a command.
REQ-008 cmd_write  input  1  1=write, 0=read.
REQ-009 cmd_addr  input  ADDR_WIDTH  target address.
REQ-010 cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumer ready.
REQ-013 rsp_rdata  output  DATA_WIDTH  read data.
REQ-014 rsp_err  output  1  slave error or timeout.
REQ-015 rsp_timeout  output  1  transfer aborted by timeout.
REQ-016 PSEL, PENABLE, PWRITE  output  1 each  APB requester controls.
REQ-017 PADDR  output  ADDR_WIDTH; PWDATA  output  DATA_WIDTH.
REQ-018 PREADY, PSLVERR  input  1 each; PRDATA  input  DATA_WIDTH.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, ACCESS and RESP; every APB and rsp_* output SHALL be registered.
REQ-020 cmd_ready SHALL equal (state==IDLE); a command SHALL be accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-021 On acceptance: cmd_write, cmd_addr and cmd_wdata SHALL be registered into PWRITE, PADDR and PWDATA; next state SETUP with PSEL=1 and PENABLE=0.
REQ-022 SETUP SHALL last exactly one cycle, then go to ACCESS with PENABLE=1 and PSEL=1.
REQ-023 PADDR, PWRITE and PWDATA SHALL hold stable from SETUP until the transfer completes.
REQ-024 In ACCESS with PREADY=1: PSEL=0 and PENABLE=0 next cycle; rsp_err=PSLVERR; rsp_rdata=PRDATA for a read with PSLVERR=0, otherwise 0; go to RESP.
REQ-025 In ACCESS with PREADY=0: the wait counter SHALL increment; when it reaches TIMEOUT_CYCLES (nonzero), the FSM SHALL drop PSEL/PENABLE, set rsp_err=1, rsp_timeout=1, rsp_rdata=0 and go to RESP.
REQ-026 The wait counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide, clear on SETUP entry, and never wrap.
REQ-027 RESP SHALL hold rsp_valid=1 with stable rsp_* until rsp_ready=1, then clear rsp_valid, rsp_err and rsp_timeout and return to IDLE.
REQ-028 Minimum latency: acceptance at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid in cycle N+3 when PREADY=1 at the first ACCESS edge.
REQ-029 No new command SHALL be accepted until the response handshake completes; one transfer is outstanding at most.
REQ-030 PREADY and PSLVERR SHALL be ignored outside ACCESS; X on PRDATA SHALL never reach rsp_rdata on error or write.

Reset
REQ-031 PRESETn low SHALL asynchronously force state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter=0.
REQ-032 Reset mid-transfer SHALL abandon the transfer with no response; cmd_ready=1 from the first edge after release.

Structure
REQ-033 Package apb_pkg SHALL hold the apb_mst_state_e enum (IDLE, SETUP, ACCESS, RESP) and the default ADDR/DATA width constants.
REQ-034 The block SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-035 Write addr 0x04, data 0xDEADBEEF, zero-wait responder -> SETUP then ACCESS with PENABLE=1, rsp_valid 3 cycles after acceptance, rsp_err=0, rsp_rdata=0.
REQ-036 Read addr 0x04 after that write, with 2 wait states -> PADDR stable over 4 PSEL cycles, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Read addr 0x40, responder PSLVERR=1 with PRDATA=X -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-038 TIMEOUT_CYCLES=4, PREADY stuck 0 -> PSEL drops after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1.
REQ-039 rsp_ready held 0 for 5 cycles while cmd_valid=1 -> rsp_* stable, cmd_ready=0 throughout, next command accepted only after the handshake.
REQ-040 PRESETn asserted during ACCESS -> PSEL/PENABLE low immediately, no rsp_valid, cmd_ready=1 after release.
